pipe_stall_ctrl: RTL and testbench
==================================

# pipe_stall_ctrl

Central stall/flush sequencer for the 5-stage pipeline. It merges the hazard conditions into one coherent set of hold and flush strobes for the PC, IF/ID, ID/EX and EX/MEM registers:
- load-use interlock between ID and EX;
- branch/jump redirect resolved in EX;
- multi-cycle multiply/divide (MDU) occupancy of EX.

It owns the MDU start/wait handshake, a stuck-MDU watchdog and optional stall/flush performance counters.

## Interface
Parameters:
- MDU_TIMEOUT, 64 — max cycles in MDU_BUSY before abort; legal 2..65535
- PERF_W, 32 — width of performance counters

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low
- if_id_valid  in  1  IF/ID holds a real instruction
- if_id_rs1, if_id_rs2  in  5 each  source registers decoded in ID
- if_id_use_rs1, if_id_use_rs2  in  1 each  instruction actually reads that source
- id_ex_valid  in  1  ID/EX holds a real instruction
- id_ex_memread  in  1  EX instruction is a load
- id_ex_rd  in  5  EX destination register
- id_ex_mdu  in  1  EX instruction is an MDU op
- ex_redirect  in  1  EX resolved a taken branch/jal/jalr
- mdu_done  in  1  MDU result valid this cycle
- pc_hold, if_id_hold, id_ex_hold  out  1 each  register keeps its value
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  register loads a bubble
- mdu_start  out  1  single-cycle MDU launch pulse
- mdu_abort  out  1  single-cycle watchdog-expiry pulse
- stall_cnt  out  PERF_W  cycles with pc_hold=1 (macro only)
- flush_cnt  out  PERF_W  accepted redirects (macro only)

## Operation
States are RUN and MDU_BUSY. Reset (rst=0 at a clock edge) gives:
- state=RUN
- watchdog=0
- counters=0

All hold/flush/start/abort outputs are 0 while rst=0, regardless of the other inputs.

RUN, evaluated in priority order:
1. **Redirect:** ex_redirect=1 → if_id_flush=1, id_ex_flush=1. No holds. Load-use is ignored. flush_cnt+1.
2. **MDU launch:** id_ex_valid & id_ex_mdu → mdu_start=1, pc_hold=if_id_hold=id_ex_hold=1, ex_mem_flush=1. Next state MDU_BUSY, watchdog=0.
3. **Load-use:** id_ex_valid & id_ex_memread & id_ex_rd≠0 & if_id_valid & ((if_id_use_rs1 & rs1==rd) | (if_id_use_rs2 & rs2==rd)) → pc_hold=if_id_hold=1, id_ex_flush=1. Exactly one bubble.
4. **Otherwise:** all strobes 0.

MDU_BUSY:
- If mdu_done=1: all strobes 0 (EX/MEM captures the result), next RUN.
- Else if watchdog==MDU_TIMEOUT-1: mdu_abort=1, id_ex_flush=1, ex_mem_flush=1, no holds, next RUN.
- Else: pc_hold=if_id_hold=id_ex_hold=1, ex_mem_flush=1, watchdog+1.
- ex_redirect and load-use are ignored in this state. mdu_done has priority over the timeout in the same cycle.

mdu_done in RUN is ignored.

Any cycle with pc_hold=1 increments stall_cnt. Both counters saturate at all-ones.

## Timing
- Hold/flush/start/abort are combinational from inputs and registered state, valid in the same cycle as the hazard.
- Load-use costs exactly 1 stall cycle.
- Redirect costs 2 squashed slots and no stall.
- An MDU op taking N cycles from mdu_start to mdu_done (N≥1) holds the PC for N cycles: the start cycle plus N-1 busy cycles. done arrives in the Nth cycle, which is not held.
- Watchdog abort fires on the MDU_TIMEOUT-th cycle after the start cycle.
- mdu_start is never asserted on two consecutive cycles.
- Reset mid-MDU_BUSY returns to RUN with no abort pulse; the MDU must be reset alongside.

## Configuration
- PIPE_STALL_PERF_EN defined: stall_cnt and flush_cnt are implemented as described.
- Undefined: both ports exist but are tied to 0, and no counter flops are inferred.

## Test plan
- **Load-use:** EX lw x5, ID add x6,x5,x1 (use_rs1=1) → exactly one cycle of pc_hold=if_id_hold=id_ex_flush=1. Same with id_ex_rd=0 → no stall.
- **Redirect priority:** ex_redirect=1 together with a load-use match → if_id_flush=id_ex_flush=1, pc_hold=0, flush_cnt 0→1.
- **MDU:** id_ex_mdu=1, mdu_done three cycles after start → mdu_start is a 1-cycle pulse, pc_hold=1 for 3 cycles, all strobes 0 in the done cycle, state back to RUN.
- **Watchdog:** MDU_TIMEOUT=4, mdu_done never arrives → mdu_abort on the 4th cycle after start with id_ex_flush=ex_mem_flush=1, then RUN. Done and timeout in the same cycle → no abort.
- **Reset mid-MDU:** rst=0 for one cycle while in MDU_BUSY → next cycle RUN, all outputs 0, counters 0, no mdu_abort.
- **Counter saturation:** PERF_W=4 with 20 stall cycles and PIPE_STALL_PERF_EN defined → stall_cnt holds at 15. Without the macro → reads 0.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, EX redirect and MDU occupancy.
// Optional stall/flush performance counters are enabled by defining PIPE_STALL_PERF_EN.
module pipe_stall_ctrl #(
    parameter int unsigned MDU_TIMEOUT = 64,
    parameter int unsigned PERF_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_id_valid,
    input  logic [4:0]        if_id_rs1,
    input  logic [4:0]        if_id_rs2,
    input  logic              if_id_use_rs1,
    input  logic              if_id_use_rs2,
    input  logic              id_ex_valid,
    input  logic              id_ex_memread,
    input  logic [4:0]        id_ex_rd,
    input  logic              id_ex_mdu,
    input  logic              ex_redirect,
    input  logic              mdu_done,
    output logic              pc_hold,
    output logic              if_id_hold,
    output logic              id_ex_hold,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              ex_mem_flush,
    output logic              mdu_start,
    output logic              mdu_abort,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt
);

    localparam int unsigned WD_W = 16;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MDU_TIMEOUT - 1);

    typedef enum logic {
        S_RUN      = 1'b0,
        S_MDU_BUSY = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [WD_W-1:0] wd, wd_nxt;

    logic load_use;
    logic mdu_launch;
    logic wd_expired;

    // Hazard detection on the current ID/EX pair
    assign load_use = id_ex_valid && id_ex_memread && (id_ex_rd != 5'd0) && if_id_valid &&
                      ((if_id_use_rs1 && (if_id_rs1 == id_ex_rd)) ||
                       (if_id_use_rs2 && (if_id_rs2 == id_ex_rd)));
    assign mdu_launch = id_ex_valid && id_ex_mdu;
    assign wd_expired = (wd == WD_LAST);

    // State and watchdog registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_RUN;
            wd    <= '0;
        end else begin
            state <= state_nxt;
            wd    <= wd_nxt;
        end
    end

    // Next-state logic; a redirect squashes a pending MDU launch
    always_comb begin
        state_nxt = state;
        wd_nxt    = wd;
        case (state)
            S_RUN: begin
                if (!ex_redirect && mdu_launch) begin
                    state_nxt = S_MDU_BUSY;
                    wd_nxt    = '0;
                end
            end
            S_MDU_BUSY: begin
                if (mdu_done || wd_expired) begin
                    state_nxt = S_RUN;
                end else begin
                    wd_nxt = wd + WD_W'(1);
                end
            end
            default: state_nxt = S_RUN;
        endcase
    end

    // Strobe decode; everything is forced low while reset is asserted
    always_comb begin
        pc_hold      = 1'b0;
        if_id_hold   = 1'b0;
        id_ex_hold   = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mdu_start    = 1'b0;
        mdu_abort    = 1'b0;
        if (rst) begin
            case (state)
                S_RUN: begin
                    if (ex_redirect) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (mdu_launch) begin
                        mdu_start    = 1'b1;
                        pc_hold      = 1'b1;
                        if_id_hold   = 1'b1;
                        id_ex_hold   = 1'b1;
                        ex_mem_flush = 1'b1;
                    end else if (load_use) begin
                        pc_hold     = 1'b1;
                        if_id_hold  = 1'b1;
                        id_ex_flush = 1'b1;
                    end
                end
                S_MDU_BUSY: begin
                    if (!mdu_done) begin
                        if (wd_expired) begin
                            mdu_abort    = 1'b1;
                            id_ex_flush  = 1'b1;
                            ex_mem_flush = 1'b1;
                        end else begin
                            pc_hold      = 1'b1;
                            if_id_hold   = 1'b1;
                            id_ex_hold   = 1'b1;
                            ex_mem_flush = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PIPE_STALL_PERF_EN
    logic              redirect_take;
    logic [PERF_W-1:0] stall_q;
    logic [PERF_W-1:0] flush_q;

    assign redirect_take = rst && (state == S_RUN) && ex_redirect;

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (pc_hold && (stall_q != '1)) begin
                stall_q <= stall_q + PERF_W'(1);
            end
            if (redirect_take && (flush_q != '1)) begin
                flush_q <= flush_q + PERF_W'(1);
            end
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: directed vectors push expected strobes/counters,
// a negedge monitor pops and compares. Counter expectations follow PIPE_STALL_PERF_EN.
module tb_pipe_stall_ctrl;

    localparam int unsigned PW = 4;

    // Strobe vector order: pc_hold, if_id_hold, id_ex_hold, if_id_flush, id_ex_flush, ex_mem_flush, mdu_start, mdu_abort
    localparam logic [7:0] NONE = 8'b0000_0000;
    localparam logic [7:0] LU   = 8'b1100_1000;
    localparam logic [7:0] RD   = 8'b0001_1000;
    localparam logic [7:0] MST  = 8'b1110_0110;
    localparam logic [7:0] MBZ  = 8'b1110_0100;
    localparam logic [7:0] ABT  = 8'b0000_1101;

    logic          clk;
    logic          rst;
    logic          if_id_valid;
    logic [4:0]    if_id_rs1;
    logic [4:0]    if_id_rs2;
    logic          if_id_use_rs1;
    logic          if_id_use_rs2;
    logic          id_ex_valid;
    logic          id_ex_memread;
    logic [4:0]    id_ex_rd;
    logic          id_ex_mdu;
    logic          ex_redirect;
    logic          mdu_done;
    logic          pc_hold;
    logic          if_id_hold;
    logic          id_ex_hold;
    logic          if_id_flush;
    logic          id_ex_flush;
    logic          ex_mem_flush;
    logic          mdu_start;
    logic          mdu_abort;
    logic [PW-1:0] stall_cnt;
    logic [PW-1:0] flush_cnt;

    typedef struct {
        int         step;
        logic [7:0] strb;
        int         s;
        int         f;
    } exp_t;

    exp_t q[$];
    int   checks;
    int   errors;
    int   step_no;

    pipe_stall_ctrl #(
        .MDU_TIMEOUT(4),
        .PERF_W     (PW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .if_id_valid  (if_id_valid),
        .if_id_rs1    (if_id_rs1),
        .if_id_rs2    (if_id_rs2),
        .if_id_use_rs1(if_id_use_rs1),
        .if_id_use_rs2(if_id_use_rs2),
        .id_ex_valid  (id_ex_valid),
        .id_ex_memread(id_ex_memread),
        .id_ex_rd     (id_ex_rd),
        .id_ex_mdu    (id_ex_mdu),
        .ex_redirect  (ex_redirect),
        .mdu_done     (mdu_done),
        .pc_hold      (pc_hold),
        .if_id_hold   (if_id_hold),
        .id_ex_hold   (id_ex_hold),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_flush (ex_mem_flush),
        .mdu_start    (mdu_start),
        .mdu_abort    (mdu_abort),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        rst           = 1'b1;
        if_id_valid   = 1'b0;
        if_id_rs1     = 5'd0;
        if_id_rs2     = 5'd0;
        if_id_use_rs1 = 1'b0;
        if_id_use_rs2 = 1'b0;
        id_ex_valid   = 1'b0;
        id_ex_memread = 1'b0;
        id_ex_rd      = 5'd0;
        id_ex_mdu     = 1'b0;
        ex_redirect   = 1'b0;
        mdu_done      = 1'b0;
    endtask

    // Load in EX, consumer in ID
    task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2);
        idle();
        id_ex_valid   = 1'b1;
        id_ex_memread = 1'b1;
        id_ex_rd      = rd;
        if_id_valid   = 1'b1;
        if_id_rs1     = rs1;
        if_id_use_rs1 = u1;
        if_id_rs2     = rs2;
        if_id_use_rs2 = u2;
    endtask

    // Queue the expectation for the inputs now applied, then advance one cycle
    task automatic step(input logic [7:0] strb, input int s, input int f);
        exp_t e;
        e.step = step_no;
        e.strb = strb;
        e.s    = s;
        e.f    = f;
        q.push_back(e);
        step_no++;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare whatever the DUT presents mid-cycle against the oldest expectation
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t       e;
            logic [7:0] got;
            int         es;
            int         ef;
            e   = q.pop_front();
            got = {pc_hold, if_id_hold, id_ex_hold, if_id_flush,
                   id_ex_flush, ex_mem_flush, mdu_start, mdu_abort};
`ifdef PIPE_STALL_PERF_EN
            es = e.s;
            ef = e.f;
`else
            es = 0;
            ef = 0;
`endif
            checks++;
            if (got !== e.strb) begin
                errors++;
                $display("FAIL step %0d strobes: got %b want %b", e.step, got, e.strb);
            end
            checks++;
            if (stall_cnt !== PW'(es)) begin
                errors++;
                $display("FAIL step %0d stall_cnt: got %0d want %0d", e.step, stall_cnt, es);
            end
            checks++;
            if (flush_cnt !== PW'(ef)) begin
                errors++;
                $display("FAIL step %0d flush_cnt: got %0d want %0d", e.step, flush_cnt, ef);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        checks  = 0;
        errors  = 0;
        step_no = 0;

        idle();
        rst = 1'b0;
        @(posedge clk);
        #1;
        // Strobes gated low during reset despite active hazards
        set_lu(5'd5, 5'd5, 1'b1, 5'd1, 1'b1);
        id_ex_mdu = 1'b1; ex_redirect = 1'b1; mdu_done = 1'b1; rst = 1'b0;
        step(NONE, 0, 0);

        idle();                                   step(NONE, 0, 0);
        // Load-use via rs1, then one bubble only
        set_lu(5'd5, 5'd5, 1'b1, 5'd1, 1'b1);    step(LU,   0, 0);
        id_ex_valid = 1'b0;                       step(NONE, 1, 0);
        set_lu(5'd0, 5'd0, 1'b1, 5'd1, 1'b0);    step(NONE, 1, 0);
        set_lu(5'd7, 5'd3, 1'b1, 5'd7, 1'b1);    step(LU,   1, 0);
        set_lu(5'd7, 5'd3, 1'b1, 5'd7, 1'b0);    step(NONE, 2, 0);
        set_lu(5'd7, 5'd7, 1'b1, 5'd7, 1'b1);
        if_id_valid = 1'b0;                       step(NONE, 2, 0);
        // Redirect beats load-use
        set_lu(5'd5, 5'd5, 1'b1, 5'd1, 1'b0);
        ex_redirect = 1'b1;                       step(RD,   2, 0);
        idle();                                   step(NONE, 2, 1);

        // MDU with done three cycles after start; redirect/load-use ignored while busy
        idle(); id_ex_valid = 1'b1; id_ex_mdu = 1'b1;
        step(MST, 2, 1);
        set_lu(5'd5, 5'd5, 1'b1, 5'd1, 1'b0);
        id_ex_mdu = 1'b1; ex_redirect = 1'b1;
        step(MBZ, 3, 1);
        step(MBZ, 4, 1);
        mdu_done = 1'b1;                          step(NONE, 5, 1);
        idle(); mdu_done = 1'b1;                  step(NONE, 5, 1);

        // Watchdog expiry on the 4th cycle after start
        idle(); id_ex_valid = 1'b1; id_ex_mdu = 1'b1;
        step(MST, 5, 1);
        step(MBZ, 6, 1);
        step(MBZ, 7, 1);
        step(MBZ, 8, 1);
        step(ABT, 9, 1);
        idle();                                   step(NONE, 9, 1);

        // Done coincident with timeout wins
        idle(); id_ex_valid = 1'b1; id_ex_mdu = 1'b1;
        step(MST, 9, 1);
        step(MBZ, 10, 1);
        step(MBZ, 11, 1);
        step(MBZ, 12, 1);
        mdu_done = 1'b1;                          step(NONE, 13, 1);
        idle();                                   step(NONE, 13, 1);

        // Reset in the middle of MDU_BUSY
        idle(); id_ex_valid = 1'b1; id_ex_mdu = 1'b1;
        step(MST, 13, 1);
        step(MBZ, 14, 1);
        rst = 1'b0;                               step(NONE, 15, 1);
        idle();                                   step(NONE, 0, 0);

        // Stall counter saturation at 15
        set_lu(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(LU, (i < 15) ? i : 15, 0);
        end
        idle();                                   step(NONE, 15, 0);

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
